// File: rtl/cpu_clock_pkg.sv
// rtl/cpu_clock_pkg.sv - shared state encoding and default timing constants for cpu_clock_ctrl
package cpu_clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_RUN_DRAIN  = 2'd1,
    ST_STEP_IDLE  = 2'd2,
    ST_STEP_PULSE = 2'd3
  } cpu_state_t;

  localparam int HALF_PERIOD_DEFAULT     = 2500000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - button synchronizer, optional debounce (CPU_CLOCK_CTRL_DEBOUNCE_EN) and press strobe
module button_debounce
`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
  import cpu_clock_pkg::*;
  #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
  )
`endif
  (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
  );

  logic sync_q1;
  logic sync_q2;
  logic level;
  logic edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] stable_cnt;
  logic          level_q;

  // Any sample that agrees with the accepted level restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q    <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_q2 == level_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == LAST) begin
      level_q    <= sync_q2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  assign level = level_q;
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= level;
    end
  end

  assign press = level & ~edge_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - run/step/halt CPU clock generator; button debounce via CPU_CLOCK_CTRL_DEBOUNCE_EN
module cpu_clock_ctrl
  import cpu_clock_pkg::*;
  #(
    parameter int HALF_PERIOD     = HALF_PERIOD_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
  )
  (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_mode,
    input  logic btn_step,
    output logic clk_cpu,
    output logic cpu_tick,
    output logic running
  );

  localparam int CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] TERM = CW'(HALF_PERIOD - 1);

  cpu_state_t    state;
  logic [CW-1:0] cnt;
  logic          terminal;
  logic          mode_press;
  logic          step_press;

  assign terminal = (cnt == TERM);

  // Unsupported parameter values elaborate this marker scope.
  if (HALF_PERIOD < 2 || DEBOUNCE_CYCLES < 1) begin : g_invalid_params
  end

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .press (mode_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .press (step_press)
  );
`else
  button_debounce u_mode_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .press (mode_press)
  );

  button_debounce u_step_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .press (step_press)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cnt      <= '0;
      clk_cpu  <= 1'b0;
      cpu_tick <= 1'b0;
      running  <= 1'b1;
    end else begin
      cpu_tick <= 1'b0;
      case (state)
        ST_RUN: begin
          if (mode_press && !clk_cpu) begin
            state   <= ST_STEP_IDLE;
            cnt     <= '0;
            running <= 1'b0;
          end else if (mode_press && !terminal) begin
            state   <= ST_RUN_DRAIN;
            cnt     <= cnt + CW'(1);
            running <= 1'b0;
          end else if (mode_press) begin
            // High phase ends on this very edge, so there is nothing left to drain.
            state   <= ST_STEP_IDLE;
            cnt     <= '0;
            clk_cpu <= 1'b0;
            running <= 1'b0;
          end else if (terminal) begin
            cnt      <= '0;
            clk_cpu  <= ~clk_cpu;
            cpu_tick <= ~clk_cpu;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_RUN_DRAIN, ST_STEP_PULSE: begin
          if (terminal) begin
            state   <= ST_STEP_IDLE;
            cnt     <= '0;
            clk_cpu <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_STEP_IDLE: begin
          cnt     <= '0;
          clk_cpu <= 1'b0;
          if (mode_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (step_press) begin
            state    <= ST_STEP_PULSE;
            clk_cpu  <= 1'b1;
            cpu_tick <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - directed bench for cpu_clock_ctrl, either CPU_CLOCK_CTRL_DEBOUNCE_EN setting
module tb_cpu_clock_ctrl;

  localparam int HP = 4;
  localparam int DB = 8;

  logic clk;
  logic rst_n;
  logic btn_mode;
  logic btn_step;
  logic clk_cpu;
  logic cpu_tick;
  logic running;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;
  int rise_cnt = 0;
  logic prev_cpu = 1'b0;
  int lat;

  cpu_clock_ctrl #(.HALF_PERIOD(HP), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_step (btn_step),
    .clk_cpu  (clk_cpu),
    .cpu_tick (cpu_tick),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (cpu_tick === 1'b1) tick_cnt++;
    if (clk_cpu === 1'b1 && prev_cpu === 1'b0) rise_cnt++;
    prev_cpu = clk_cpu;
  endtask

  initial begin
    int   hi;
    int   t0;
    int   r0;
    bit   found;
    logic exp_clk;
    logic exp_tick;

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
    lat = 3 + DB;
`else
    lat = 3;
`endif

    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_step = 1'b0;
    repeat (3) cyc();
    chk("reset_clk_cpu", clk_cpu, 1'b0);
    chk("reset_tick", cpu_tick, 1'b0);
    chk("reset_running", running, 1'b1);

    rst_n = 1'b1;
    repeat (5) cyc();
    chk("pre_reset_high", clk_cpu, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clk_cpu", clk_cpu, 1'b0);
    chk("async_reset_running", running, 1'b1);
    prev_cpu = 1'b0;
    cyc();
    rst_n = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      cyc();
      exp_clk  = (k >= 4) && (((k - 4) % 8) < 4);
      exp_tick = (k == 4) || (k == 12);
      chk($sformatf("run_clk_cpu_e%0d", k), clk_cpu, exp_clk);
      chk($sformatf("run_tick_e%0d", k), cpu_tick, exp_tick);
    end
    chk("run_running", running, 1'b1);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (clk_cpu === 1'b1) found = 1'b1;
    end
    chk("drain_wait_rise", found, 1'b1);
    btn_mode = 1'b1;
    hi = 1;
    for (int j = 1; j < lat; j++) begin
      cyc();
      hi = (clk_cpu === 1'b1) ? hi + 1 : 0;
    end
    chk("drain_pre_running", running, 1'b1);
    cyc();
    hi = (clk_cpu === 1'b1) ? hi + 1 : 0;
    chk("drain_strobe_running", running, 1'b0);
    chk("drain_strobe_clk_cpu", clk_cpu, 1'b1);
    cyc();
    chk("drain_fall", clk_cpu, 1'b0);
    chk_n("drain_high_len", hi, HP);
    btn_mode = 1'b0;
    t0 = tick_cnt;
    r0 = rise_cnt;
    repeat (20) cyc();
    chk_n("drain_no_ticks", tick_cnt - t0, 0);
    chk_n("drain_no_rises", rise_cnt - r0, 0);
    chk("drain_idle_running", running, 1'b0);

    btn_step = 1'b1;
    for (int j = 1; j < lat; j++) begin
      cyc();
      chk($sformatf("step_wait_e%0d", j), clk_cpu, 1'b0);
    end
    t0 = tick_cnt;
    r0 = rise_cnt;
    cyc();
    chk("step_latency_clk_cpu", clk_cpu, 1'b1);
    chk("step_tick", cpu_tick, 1'b1);
    btn_step = 1'b0;
    cyc();
    btn_step = 1'b1;
    chk("step_hold1", clk_cpu, 1'b1);
    chk("step_tick_once", cpu_tick, 1'b0);
    cyc();
    chk("step_hold2", clk_cpu, 1'b1);
    cyc();
    chk("step_hold3", clk_cpu, 1'b1);
    cyc();
    chk("step_fall", clk_cpu, 1'b0);
    repeat (20) cyc();
    chk_n("step_single_rise", rise_cnt - r0, 1);
    chk_n("step_single_tick", tick_cnt - t0, 1);
    chk("step_running", running, 1'b0);
    btn_step = 1'b0;
    repeat (20) cyc();

`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
    t0 = tick_cnt;
    r0 = rise_cnt;
    for (int s = 0; s < 10; s++) begin
      btn_step = ((s % 2) == 0);
      repeat (3) cyc();
    end
    btn_step = 1'b1;
    repeat (40) cyc();
    chk_n("bounce_one_rise", rise_cnt - r0, 1);
    chk_n("bounce_one_tick", tick_cnt - t0, 1);
    btn_step = 1'b0;
    repeat (20) cyc();
    r0 = rise_cnt;
    btn_step = 1'b1;
    repeat (6) cyc();
    btn_step = 1'b0;
    repeat (30) cyc();
    chk_n("blip_no_rise", rise_cnt - r0, 0);
`endif

    btn_mode = 1'b1;
    btn_step = 1'b1;
    for (int j = 1; j < lat; j++) cyc();
    cyc();
    chk("simul_running", running, 1'b1);
    chk("simul_no_pulse", clk_cpu, 1'b0);
    chk("simul_no_tick", cpu_tick, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      cyc();
      chk($sformatf("simul_low_e%0d", j), clk_cpu, 1'b0);
    end
    cyc();
    chk("simul_first_rise", clk_cpu, 1'b1);
    chk("simul_first_tick", cpu_tick, 1'b1);
    btn_mode = 1'b0;
    btn_step = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("midpulse_reset_clk_cpu", clk_cpu, 1'b0);
    chk("midpulse_reset_tick", cpu_tick, 1'b0);
    chk("midpulse_reset_running", running, 1'b1);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
